// File: rtl/fetch_pc_if.sv
// Fetch-stage bundle: branch/hazard controls in, instruction-memory port, PC and IF/ID view out.
// The master side is the fetch unit; the slave side is the surrounding pipeline and memory.
interface fetch_pc_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 8
);
  logic               flush;
  logic [ADDR_W-1:0]  branch_target;
  logic               stall;
  logic               halt_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] ifid_instr;
  logic [ADDR_W-1:0]  ifid_pc1;
  logic               ifid_valid;
  logic               halted;

  modport master (
    input  flush, branch_target, stall, halt_req, imem_data,
    output imem_addr, pc, ifid_instr, ifid_pc1, ifid_valid, halted
  );

  modport slave (
    output flush, branch_target, stall, halt_req, imem_data,
    input  imem_addr, pc, ifid_instr, ifid_pc1, ifid_valid, halted
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC and the IF/ID register, loads the start PC from the
// reset vector, and applies branch redirect, hazard stall and HLT freeze in that priority.
module fetch_pc_unit #(
  parameter int                ADDR_W         = 8,
  parameter int                INSTR_W        = 8,
  parameter logic [ADDR_W-1:0]  RESET_VEC_ADDR = 8'h00,
  parameter logic [INSTR_W-1:0] NOP_WORD       = 8'h00
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_pc_if.master      bus
);

  typedef enum logic [1:0] {
    S_VEC  = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [ADDR_W-1:0]  ifid_pc1_q, ifid_pc1_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic               halted_q, halted_d;
  logic [ADDR_W-1:0]  pc_inc;

  assign pc_inc = pc_q + ADDR_W'(1);

  // NOTE: every signal written here gets its hold value first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc1_d   = ifid_pc1_q;
    ifid_valid_d = ifid_valid_q;
    halted_d     = halted_q;

    unique case (state_q)
      S_VEC: begin
        // The vector word is the start PC itself; controls are ignored for this one cycle.
        pc_d         = ADDR_W'(bus.imem_data);
        ifid_instr_d = NOP_WORD;
        ifid_pc1_d   = '0;
        ifid_valid_d = 1'b0;
        state_d      = S_RUN;
      end

      S_RUN: begin
        if (bus.flush) begin
          // A taken branch squashes the fetch in flight, including a younger HLT.
          pc_d         = bus.branch_target;
          ifid_instr_d = NOP_WORD;
          ifid_pc1_d   = '0;
          ifid_valid_d = 1'b0;
        end else if (bus.stall) begin
          pc_d = pc_q;
        end else if (bus.halt_req) begin
          ifid_instr_d = NOP_WORD;
          ifid_pc1_d   = '0;
          ifid_valid_d = 1'b0;
          halted_d     = 1'b1;
          state_d      = S_HALT;
        end else begin
          ifid_instr_d = bus.imem_data;
          ifid_pc1_d   = pc_inc;
          ifid_valid_d = 1'b1;
          pc_d         = pc_inc;
        end
      end

      S_HALT: begin
        halted_d = 1'b1;
      end

      default: begin
        state_d = S_VEC;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_VEC;
      pc_q         <= '0;
      ifid_instr_q <= NOP_WORD;
      ifid_pc1_q   <= '0;
      ifid_valid_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc1_q   <= ifid_pc1_d;
      ifid_valid_q <= ifid_valid_d;
      halted_q     <= halted_d;
    end
  end

  assign bus.imem_addr  = (state_q == S_VEC) ? RESET_VEC_ADDR : pc_q;
  assign bus.pc         = pc_q;
  assign bus.ifid_instr = ifid_instr_q;
  assign bus.ifid_pc1   = ifid_pc1_q;
  assign bus.ifid_valid = ifid_valid_q;
  assign bus.halted     = halted_q;

endmodule
